// File: rtl/fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_port_arbiter
//
// Sits in front of one 12-bit I/O FIFO. It shares the FIFO's single write port
// between the host loader (req0) and the CPU output path (req1). It tracks
// occupancy so that full/empty can be presented, because the FIFO itself does
// not provide them. It stops consumer advances on an empty FIFO, and it
// sequences flushes through the FIFO's synchronous reset.
//
// Build option:
//   FIFO_ARB_FIXED_PRIO_EN  defined   -> req0 always wins when both requesters
//                                        are valid, and no last_grant flop is
//                                        built.
//                           undefined -> round-robin between the two
//                                        requesters (default).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   flush         one-cycle pulse that discards the FIFO contents
//   req0_valid    host loader has a word to write
//   req0_data     host loader word
//   req0_ready    host word accepted this cycle (combinational)
//   req1_valid    CPU has a word to write
//   req1_data     CPU word
//   req1_ready    CPU word accepted this cycle (combinational)
//   rd_req        consumer wants to advance past the head word
//   fifo_write    to FIFO data_write (combinational)
//   fifo_data_in  to FIFO data_in (combinational; 0 when nothing is granted)
//   fifo_adv      to FIFO data_adv (combinational)
//   fifo_rst      to FIFO rst, which is synchronous inside the FIFO
//   count         current occupancy, 0 .. 2^DEPTH_LOG2-1
//   full          count == 2^DEPTH_LOG2-1
//   empty         count == 0
// -----------------------------------------------------------------------------
module fifo_port_arbiter #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req0_valid,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  input  logic                  rd_req,
  output logic                  fifo_write,
  output logic [DATA_W-1:0]     fifo_data_in,
  output logic                  fifo_adv,
  output logic                  fifo_rst,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  // The FIFO detects empty by pointer equality, so one slot always stays free.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DEPTH_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               grant0, grant1;

  // Occupancy decode
  assign count = count_q;
  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Fixed priority: req0 wins whenever it is valid.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`else
  logic last_grant_q, last_grant_d;

  // Round-robin: on a tie, grant the requester that did not win last.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & ~grant0;
  end

  // last_grant moves only when a write is actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (fifo_write) begin
      last_grant_d = req1_ready;
    end
  end

  // Reset to 1 so that req0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // State and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state, count update and port outputs
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fifo_rst     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    fifo_write   = 1'b0;
    fifo_adv     = 1'b0;
    fifo_data_in = '0;

    case (state_q)
      ST_FLUSH: begin
        fifo_rst = 1'b1;
        count_d  = '0;
        state_d  = ST_SETTLE;
      end

      // One cycle lets the FIFO's registered data_out settle after the reset.
      ST_SETTLE: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        req0_ready = grant0 & ~full;
        req1_ready = grant1 & ~full;
        fifo_write = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (req0_ready) begin
          fifo_data_in = req0_data;
        end else if (req1_ready) begin
          fifo_data_in = req1_data;
        end
        fifo_adv = rd_req & ~empty;

        // The write and advance of a flush cycle still reach the FIFO, but
        // the FIFO reset that follows discards them. The count therefore
        // drops to 0 on entry to FLUSH.
        if (flush) begin
          state_d = ST_FLUSH;
          count_d = '0;
        end else if (fifo_write && !fifo_adv) begin
          count_d = count_q + CNT_W'(1);
        end else if (!fifo_write && fifo_adv) begin
          count_d = count_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_port_arbiter
//
// Directed bench for fifo_port_arbiter. The inputs change 1 ns after a rising
// edge. The combinational outputs and count are sampled 1 ns after that, which
// is well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_fifo_port_arbiter;

  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned DATA_W     = 12;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                req0_valid;
  logic [DATA_W-1:0]   req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [DATA_W-1:0]   req1_data;
  logic                req1_ready;
  logic                rd_req;
  logic                fifo_write;
  logic [DATA_W-1:0]   fifo_data_in;
  logic                fifo_adv;
  logic                fifo_rst;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;

  int n_pass;
  int n_total;

  fifo_port_arbiter #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rd_req       (rd_req),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .fifo_adv     (fifo_adv),
    .fifo_rst     (fifo_rst),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0_data = 12'h111;
    req1_data = 12'h222;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_total++; if (fifo_rst !== 1'b1) $display("FAIL reset_fifo_rst got %0b want 1", fifo_rst); else n_pass++;
    n_total++; if (fifo_write !== 1'b0) $display("FAIL reset_fifo_write got %0b want 0", fifo_write); else n_pass++;
    n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", empty, full); else n_pass++;
    n_total++; if (count !== 11'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (fifo_data_in !== 12'h000) $display("FAIL reset_data got %h want 000", fifo_data_in); else n_pass++;
    req0_valid = 1'b1;
    rd_req     = 1'b1;
    #1;
    n_total++; if (req0_ready !== 1'b0 || fifo_adv !== 1'b0) $display("FAIL reset_ready_adv got rdy=%0b adv=%0b want 0/0", req0_ready, fifo_adv); else n_pass++;
    step();
    rst = 1'b0;
    #1;
    // FLUSH cycle
    n_total++; if (fifo_rst !== 1'b1 || req0_ready !== 1'b0) $display("FAIL rel_flush got rst=%0b rdy=%0b want 1/0", fifo_rst, req0_ready); else n_pass++;
    step();
    // SETTLE cycle
    n_total++; if (fifo_rst !== 1'b0 || req0_ready !== 1'b0) $display("FAIL rel_settle got rst=%0b rdy=%0b want 0/0", fifo_rst, req0_ready); else n_pass++;
    step();
    // RUN cycle
    n_total++; if (req0_ready !== 1'b1 || fifo_write !== 1'b1) $display("FAIL rel_run_ready got rdy=%0b wr=%0b want 1/1", req0_ready, fifo_write); else n_pass++;
    n_total++; if (empty !== 1'b1 || count !== 11'd0 || fifo_adv !== 1'b0) $display("FAIL rel_run_empty got empty=%0b count=%0d adv=%0b want 1/0/0", empty, count, fifo_adv); else n_pass++;
    req0_valid = 1'b0;
    rd_req     = 1'b0;
    step();
    n_total++; if (count !== 11'd0) $display("FAIL rel_no_write got count=%0d want 0", count); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] exp_data [4];
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp_data = '{12'h111, 12'h111, 12'h111, 12'h111};
`else
    exp_data = '{12'h111, 12'h222, 12'h111, 12'h222};
`endif
    req0_data  = 12'h111;
    req1_data  = 12'h222;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (fifo_data_in !== exp_data[i] || fifo_write !== 1'b1) $display("FAIL rr_data_%0d got %h wr=%0b want %h wr=1", i, fifo_data_in, fifo_write, exp_data[i]); else n_pass++;
      step();
    end
    idle_inputs();
    #1;
    n_total++; if (count !== 11'd4) $display("FAIL rr_count got %0d want 4", count); else n_pass++;
    n_total++; if (fifo_write !== 1'b0 || fifo_data_in !== 12'h000) $display("FAIL rr_idle got wr=%0b data=%h want 0/000", fifo_write, fifo_data_in); else n_pass++;
  endtask

  task automatic test_single_req1();
    req1_valid = 1'b1;
    #1;
    n_total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || fifo_data_in !== 12'h222) $display("FAIL single_req1 got r1=%0b r0=%0b data=%h want 1/0/222", req1_ready, req0_ready, fifo_data_in); else n_pass++;
    step();
    req1_valid = 1'b0;
    #1;
    n_total++; if (count !== 11'd5) $display("FAIL single_count got %0d want 5", count); else n_pass++;
  endtask

  task automatic test_flush();
    flush      = 1'b1;
    req0_valid = 1'b1;
    #1;
    n_total++; if (fifo_write !== 1'b1 || fifo_rst !== 1'b0 || count !== 11'd5) $display("FAIL flush_cycle got wr=%0b rst=%0b count=%0d want 1/0/5", fifo_write, fifo_rst, count); else n_pass++;
    step();
    flush = 1'b0;
    #1;
    n_total++; if (fifo_rst !== 1'b1 || count !== 11'd0 || req0_ready !== 1'b0) $display("FAIL flush_state got rst=%0b count=%0d rdy=%0b want 1/0/0", fifo_rst, count, req0_ready); else n_pass++;
    step();
    n_total++; if (fifo_rst !== 1'b0 || req0_ready !== 1'b0 || count !== 11'd0) $display("FAIL flush_settle got rst=%0b rdy=%0b count=%0d want 0/0/0", fifo_rst, req0_ready, count); else n_pass++;
    req0_valid = 1'b0;
    step();
    n_total++; if (empty !== 1'b1 || count !== 11'd0) $display("FAIL flush_run got empty=%0b count=%0d want 1/0", empty, count); else n_pass++;
  endtask

  task automatic test_empty_adv();
    rd_req = 1'b1;
    #1;
    n_total++; if (fifo_adv !== 1'b0) $display("FAIL empty_adv got %0b want 0", fifo_adv); else n_pass++;
    step();
    n_total++; if (count !== 11'd0) $display("FAIL empty_count got %0d want 0", count); else n_pass++;
    rd_req     = 1'b0;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    rd_req     = 1'b1;
    #1;
    n_total++; if (fifo_adv !== 1'b1 || count !== 11'd1) $display("FAIL one_adv got adv=%0b count=%0d want 1/1", fifo_adv, count); else n_pass++;
    step();
    rd_req = 1'b0;
    #1;
    n_total++; if (count !== 11'd0 || empty !== 1'b1) $display("FAIL one_drain got count=%0d empty=%0b want 0/1", count, empty); else n_pass++;
  endtask

  task automatic test_full();
    req0_valid = 1'b1;
    repeat (1023) step();
    #1;
    n_total++; if (count !== 11'd1023 || full !== 1'b1) $display("FAIL full_count got count=%0d full=%0b want 1023/1", count, full); else n_pass++;
    n_total++; if (req0_ready !== 1'b0 || fifo_write !== 1'b0) $display("FAIL full_block got rdy=%0b wr=%0b want 0/0", req0_ready, fifo_write); else n_pass++;
    rd_req = 1'b1;
    #1;
    n_total++; if (fifo_adv !== 1'b1 || fifo_write !== 1'b0) $display("FAIL full_adv got adv=%0b wr=%0b want 1/0", fifo_adv, fifo_write); else n_pass++;
    step();
    n_total++; if (count !== 11'd1022 || full !== 1'b0) $display("FAIL full_after_adv got count=%0d full=%0b want 1022/0", count, full); else n_pass++;
    // Write and advance together leave the count unchanged.
    n_total++; if (fifo_adv !== 1'b1 || fifo_write !== 1'b1) $display("FAIL both_ops got adv=%0b wr=%0b want 1/1", fifo_adv, fifo_write); else n_pass++;
    step();
    n_total++; if (count !== 11'd1022) $display("FAIL both_count got %0d want 1022", count); else n_pass++;
    rd_req = 1'b0;
    step();
    req0_valid = 1'b0;
    #1;
    n_total++; if (count !== 11'd1023 || full !== 1'b1) $display("FAIL refill got count=%0d full=%0b want 1023/1", count, full); else n_pass++;
  endtask

  task automatic test_async_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    req1_valid = 1'b1;
    repeat (300) step();
    req1_valid = 1'b0;
    #1;
    n_total++; if (count !== 11'd300) $display("FAIL pre_rst_count got %0d want 300", count); else n_pass++;
    req0_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_total++; if (count !== 11'd0 || fifo_rst !== 1'b1) $display("FAIL async_rst got count=%0d rst=%0b want 0/1", count, fifo_rst); else n_pass++;
    n_total++; if (req0_ready !== 1'b0 || fifo_write !== 1'b0 || empty !== 1'b1) $display("FAIL async_rst_out got rdy=%0b wr=%0b empty=%0b want 0/0/1", req0_ready, fifo_write, empty); else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_total++; if (req0_ready !== 1'b0) $display("FAIL rerel_settle got rdy=%0b want 0", req0_ready); else n_pass++;
    step();
    n_total++; if (req0_ready !== 1'b1) $display("FAIL rerel_run got rdy=%0b want 1", req0_ready); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_round_robin();
    test_single_req1();
    test_flush();
    test_empty_adv();
    test_full();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Shares the single write port of one 12-bit I/O FIFO between two requesters: req0 (host loader) and req1 (CPU output).
- Tracks FIFO occupancy so it can present full/empty, which the FIFO itself does not provide.
- Gates consumer advance requests so the read pointer never moves on an empty FIFO.
- Sequences flushes by driving the FIFO's synchronous reset; sits directly in front of each I/O FIFO instance.

Parameters:
- DEPTH_LOG2, 10, log2 of FIFO depth; must match the FIFO's address width (1024 entries).
- DATA_W, 12, data word width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  one-cycle pulse requesting that FIFO contents be discarded.
- req0_valid  in  1  host loader has a word to write.
- req0_data  in  DATA_W  host loader word.
- req0_ready  out  1  host word accepted this cycle when high with req0_valid.
- req1_valid  in  1  CPU has a word to write.
- req1_data  in  DATA_W  CPU word.
- req1_ready  out  1  CPU word accepted this cycle when high with req1_valid.
- rd_req  in  1  consumer requests advance past the current head word.
- fifo_write  out  1  to FIFO data_write.
- fifo_data_in  out  DATA_W  to FIFO data_in.
- fifo_adv  out  1  to FIFO data_adv.
- fifo_rst  out  1  to FIFO rst (synchronous in the FIFO).
- count  out  DEPTH_LOG2+1  current occupancy, range 0..2^DEPTH_LOG2-1.
- full  out  1  count == 2^DEPTH_LOG2-1.
- empty  out  1  count == 0.

Behaviour:
- Capacity: usable capacity is 2^DEPTH_LOG2-1 words (1023). The FIFO signals empty on pointer equality, so one slot is always kept free.
- States: RUN, FLUSH, SETTLE. The state register, count and last_grant are the only flops.
- Reset (async):
  - state=FLUSH, count=0, last_grant=1 (so req0 wins the first tie).
  - Outputs while in reset: fifo_rst=1; fifo_write=0; fifo_adv=0; both ready=0; empty=1; full=0.
- FLUSH: fifo_rst=1, all ready=0, fifo_adv=0, count forced to 0. Unconditional next state: SETTLE.
- SETTLE: fifo_rst=0, all ready=0, fifo_adv=0. Gives the FIFO's registered data_out one cycle to settle. Next state: RUN.
- RUN:
  - flush=1 -> FLUSH next cycle. Any write and advance in that same cycle are still performed. count then goes to 0 in FLUSH regardless.
- Grant (combinational, RUN only, full=0):
  - Only one valid -> grant that requester.
  - Both valid -> grant the requester not equal to last_grant (round-robin).
  - last_grant updates only on an accepted write.
  - reqN_ready = grantN & RUN & !full.
  - req ready may depend on valid; valid must not depend on ready.
- fifo_write = (req0_valid&req0_ready) | (req1_valid&req1_ready), combinational.
- fifo_data_in = data of the granted requester; hold 0 when no grant.
- fifo_adv = rd_req & !empty & RUN, combinational.
- count update per edge: +1 on fifo_write, -1 on fifo_adv.
  - Simultaneous write and advance -> count unchanged.
  - Never wraps; full blocks writes and empty blocks advances.
- full and empty are decoded combinationally from count.
- Latency: an accepted word is stored at the same edge. It is visible on the FIFO's data_out after one further edge (the FIFO's registered read).
- Wrap-around: pointer wrap is handled inside the FIFO. The arbiter relies only on count, which matches (in_addr-out_addr) mod 2^DEPTH_LOG2 at all times.
- rst asserted mid-transfer: the pending word is lost, count=0, and the arbiter re-enters FLUSH.
- rst deasserted: the FLUSH→SETTLE→RUN sequence runs before any ready.

Optional Feature:
- Macro: FIFO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins when both requesters are valid. last_grant is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Release rst -> fifo_rst high 1 cycle (FLUSH), ready low 2 cycles. req0_ready=1 on the 3rd cycle with req0_valid=1; empty=1, count=0.
- Both valid continuously with data 0x111/0x222, 4 accepts -> fifo_data_in sequence 0x111,0x222,0x111,0x222; count=4.
  - With FIFO_ARB_FIXED_PRIO_EN: 0x111 four times.
- Write 1023 words -> full=1, req0_ready=0.
  - rd_req and req0_valid together in the same cycle -> fifo_adv=1, write blocked, count=1022.
  - Next cycle -> write accepted, count=1023.
- Empty FIFO, rd_req=1 -> fifo_adv=0, count stays 0. One write then rd_req -> fifo_adv=1 one cycle later, count returns to 0.
- count=5, flush pulse together with a write -> write accepted that cycle; then FLUSH (fifo_rst=1, count=0), SETTLE, RUN; empty=1.
- Assert rst asynchronously mid-cycle with count=300 -> count=0 and fifo_rst=1 immediately, without waiting for a clock edge.
